// File: rtl/mdu_pkg.sv
// Shared types and constants for the M-extension multiply issue controller.
package mdu_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam int MDU_TIMEOUT_DEFAULT = 32;

endpackage

// File: rtl/mdu_issue.sv
// Issue/stall controller between EX decode and the Booth radix-4 multiplier.
// Latency: accept -> wb_valid_o = multiplier ready latency + 1; stalls until writeback accepts.
module mdu_issue
    import mdu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MDU_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mul_valid_o,
    output logic [2:0]  mul_op_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [31:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    input  logic        wb_ready_i,
    output logic        err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mdu_state_t      r_state;
    mdu_op_t         r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [4:0]      r_rd;
    logic            r_mul_valid;
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [31:0]     r_wb_data;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic            w_accept;

    assign w_accept = req_valid_i && !req_op_i[2] && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_op        <= MUL;
            r_a         <= '0;
            r_b         <= '0;
            r_rd        <= '0;
            r_mul_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_err <= 1'b0;
            // Flush outranks a same-cycle multiplier or writeback handshake.
            if (flush_i) begin
                r_state     <= IDLE;
                r_mul_valid <= 1'b0;
                r_wb_valid  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // rd==0 requests are consumed without dispatch.
                        if (w_accept && (req_rd_i != 5'd0)) begin
                            r_op        <= mdu_op_t'(req_op_i);
                            r_a         <= req_rs1_i;
                            r_b         <= req_rs2_i;
                            r_rd        <= req_rd_i;
                            r_mul_valid <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= BUSY;
                        end
                    end
                    BUSY: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (mul_ready_i) begin
                            r_wb_data   <= mul_result_i;
                            r_wb_rd     <= r_rd;
                            r_wb_valid  <= 1'b1;
                            r_mul_valid <= 1'b0;
                            r_state     <= DONE;
                        end else if (r_cnt == CNT_LAST) begin
                            r_mul_valid <= 1'b0;
                            r_err       <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                    DONE: begin
                        if (wb_ready_i) begin
                            r_wb_valid <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign req_ready_o = (r_state == IDLE);
    assign stall_o     = (r_state != IDLE);
    assign mul_valid_o = r_mul_valid;
    assign mul_op_o    = r_op;
    assign mul_a_o     = r_a;
    assign mul_b_o     = r_b;
    assign wb_valid_o  = r_wb_valid;
    assign wb_rd_o     = r_wb_rd;
    assign wb_data_o   = r_wb_data;
    assign err_o       = r_err;

endmodule

// File: doc/mdu_issue.md
Name: mdu_issue

Overview:
- Issue/stall controller between the EX-stage decode and the Booth radix-4 multiplier.
- Accepts one M-extension multiply request (MUL/MULH/MULHSU/MULHU) and latches the operands.
- Holds the multiplier's valid high until the multiplier pulses ready, then captures the 32-bit result.
- Presents the result to writeback with a valid/ready handshake, stalls the pipeline while busy, and handles flush and hang timeout.

Parameters:
- TIMEOUT_CYCLES, 32, maximum cycles in BUSY before an abort with err_o; must be at least 20.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  1  multiply request present.
- req_ready_o  out  1  block can accept a request (combinational: state==IDLE).
- req_op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is not this block's.
- req_rs1_i  in  32  multiplicand.
- req_rs2_i  in  32  multiplier.
- req_rd_i  in  5  destination register.
- flush_i  in  1  kill in-flight operation.
- stall_o  out  1  pipeline stall (combinational: state!=IDLE).
- mul_valid_o  out  1  registered; held high for the whole multiply.
- mul_op_o  out  3  latched op.
- mul_a_o  out  32  latched rs1.
- mul_b_o  out  32  latched rs2.
- mul_result_i  in  32  multiplier result.
- mul_ready_i  in  1  one-cycle result-valid pulse from the multiplier.
- wb_valid_o  out  1  result available.
- wb_rd_o  out  5  destination register.
- wb_data_o  out  32  product word.
- wb_ready_i  in  1  writeback accepts.
- err_o  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst_ni=0 at posedge): state=IDLE; mul_valid_o, wb_valid_o, err_o=0; mul_op_o/a/b, wb_rd_o, wb_data_o=0; timeout counter=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept when req_valid_i=1, req_op_i[2]=0, flush_i=0.
  - If req_rd_i!=0: latch op/rs1/rs2/rd, set mul_valid_o=1, counter=0, go BUSY.
  - If req_rd_i==0: request is accepted and discarded; no dispatch, no wb, stay IDLE.
  - req_op_i[2]=1: not accepted; req_ready_o still high; no effect.
- BUSY:
  - Counter increments each cycle.
  - mul_valid_o and operands stay stable until exit.
  - On mul_ready_i=1: wb_data_o<=mul_result_i, wb_rd_o<=latched rd, wb_valid_o<=1, mul_valid_o<=0, go DONE.
  - mul_valid_o drops at the same edge the result is captured, so the multiplier returns to idle and does not re-issue.
- DONE:
  - wb_valid_o, wb_rd_o, wb_data_o held stable until wb_ready_i=1.
  - On that edge: wb_valid_o<=0, go IDLE. No new request is accepted in that cycle (req_ready_o=0).
- Timeout: in BUSY, if counter reaches TIMEOUT_CYCLES-1 without mul_ready_i: mul_valid_o<=0, err_o<=1 for one cycle, no wb, go IDLE.
- Flush (any state; priority over every other event including a same-cycle mul_ready_i or wb_ready_i):
  - Next edge: mul_valid_o=0, wb_valid_o=0, err_o=0, state=IDLE; the result is discarded.
  - In IDLE, flush also blocks acceptance.
- Reset mid-operation behaves as flush plus clearing all registers.
- The result word is exactly what the multiplier returns:
  - MUL gives bits [31:0] of the product.
  - MULH/MULHSU/MULHU give bits [63:32] with signed×signed, signed×unsigned, unsigned×unsigned operands respectively.
  - This block performs no arithmetic.
- Latency: request accept to wb_valid_o = (multiplier ready latency)+1 cycles; with the current multiplier, ready arrives 19 cycles after mul_valid_o rises.

Decomposition:
- Shared package mdu_pkg:
  - mdu_op_t enum: MUL=3'b000, MULH=3'b001, MULHSU=3'b010, MULHU=3'b011.
  - mdu_state_t enum: IDLE, BUSY, DONE.
  - Constant MDU_TIMEOUT_DEFAULT=32.
- Single module; the multiplier is instantiated by the parent, not inside this block.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD, rd=5; wb_ready_i tied 1 -> one wb_valid_o pulse, wb_data_o=0xFFFFFFEB, wb_rd_o=5; stall_o high from accept to wb; mul_valid_o high exactly until ready.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Writeback backpressure: wb_ready_i=0 for 5 cycles after wb_valid_o -> data/rd stable; req_ready_o=0 throughout; IDLE one cycle after wb_ready_i=1.
- flush_i at cycle 8 of BUSY -> mul_valid_o=0 next cycle; no wb_valid_o; a follow-up MUL 3×4 yields 12.
- rd=0 request -> no mul_valid_o, no wb_valid_o, stall_o stays 0. Op 3'b100 -> ignored.
- Stub multiplier never returns ready; TIMEOUT_CYCLES=32 -> err_o pulses once 32 cycles after accept; state back to IDLE; no wb.
